// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for the iterative divider; owns HI/LO.
// Issues DIV/DIVU, stalls EX until completion, drains cancelled divisions.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_rs_value,
    input  logic [31:0] ex_rt_value,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic        div_en,
    output logic        div_signed,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic        div_busy,
    input  logic        div_complete,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;
    logic   is_div;
    logic   issue;
    logic   commit;
    logic   mt_ok;
    logic   wr_mthi;
    logic   wr_mtlo;

    assign is_div = ex_valid & ((ex_op == OP_DIV) | (ex_op == OP_DIVU));

    always_comb begin
        state_nxt = state;
        ex_stall  = 1'b0;
        issue     = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                // A busy divider (e.g. still finishing a drained op) holds the issue.
                if (is_div & ~ex_flush) begin
                    ex_stall = 1'b1;
                    if (~div_busy) begin
                        issue     = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                ex_stall = ~(div_complete | ex_flush);
                if (ex_flush)
                    state_nxt = div_complete ? S_IDLE : S_DRAIN;
                else if (div_complete) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                ex_stall = is_div & ~ex_flush;
                if (div_complete)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!resetn)
            ex_stall = 1'b0;
    end

    assign mt_ok   = ex_valid & ~ex_flush & ~ex_stall;
    assign wr_mthi = mt_ok & (ex_op == OP_MTHI);
    assign wr_mtlo = mt_ok & (ex_op == OP_MTLO);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            div_en     <= 1'b0;
            div_signed <= 1'b0;
            dividend   <= '0;
            divisor    <= '0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state  <= state_nxt;
            div_en <= issue;
            // Operands stay put after issue so the divider may sample them late.
            if (issue) begin
                dividend   <= ex_rs_value;
                divisor    <= ex_rt_value;
                div_signed <= (ex_op == OP_DIV);
            end
            if (commit) begin
                lo <= quotient;
                hi <= remainder;
            end else begin
                if (wr_mthi) hi <= ex_rs_value;
                if (wr_mtlo) lo <= ex_rs_value;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: 35-cycle divider model, directed scenarios, then
// random instruction streams checked against an architectural HI/LO model.
module tb_div_issue_ctrl;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs_value;
    logic [31:0] ex_rt_value;
    logic        ex_flush;
    logic        ex_stall;
    logic        div_en;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_complete;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        prev_en = 1'b0;

    div_issue_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_rs_value  (ex_rs_value),
        .ex_rt_value  (ex_rt_value),
        .ex_flush     (ex_flush),
        .ex_stall     (ex_stall),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_busy     (div_busy),
        .div_complete (div_complete),
        .quotient     (quotient),
        .remainder    (remainder),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural divide result {quotient, remainder}, including the
    // divide-by-zero and signed-overflow conventions of the team divider.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0)
            return {32'hFFFF_FFFF, a};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'h8000_0000, 32'h0};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    // Divider model: start sampled at the div_en edge, complete 34 cycles later.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        spur = 1'b0;
    logic [31:0] spur_val = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (div_en) begin
            m_busy     <= 1'b1;
            m_cnt      <= 33;
            {m_q, m_r} <= ref_div(div_signed, dividend, divisor);
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    assign div_busy     = m_busy;
    assign div_complete = (m_busy && m_cnt == 0) || spur;
    assign quotient     = spur ? spur_val  : m_q;
    assign remainder    = spur ? ~spur_val : m_r;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; check per-cycle div_en rules.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk1("div_en_back_to_back", div_en & prev_en, 1'b0);
        chk1("div_en_while_busy", div_en & div_busy, 1'b0);
        prev_en = div_en;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_valid    = 1'b1;
        ex_op       = op;
        ex_rs_value = a;
        ex_rt_value = b;
        ex_flush    = 1'b0;
    endtask

    task automatic bubble();
        ex_valid = 1'b0;
        ex_op    = OP_NONE;
        ex_flush = 1'b0;
    endtask

    // Full uninterrupted division starting at the next cycle (T).
    task automatic div_seq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi);
        cyc();
        set_instr(op, a, b);
        mid();
        chk1("T_stall", ex_stall, 1'b1);
        chk1("T_div_en", div_en, 1'b0);
        chk32("T_hi_prev", hi, exp_hi);
        chk32("T_lo_prev", lo, exp_lo);
        for (int k = 1; k <= 35; k++) begin
            cyc();
            mid();
            chk1("div_en_pulse", div_en, k == 1);
            chk1("stall_window", ex_stall, k < 35);
            if (k == 1) begin
                chk32("dividend", dividend, a);
                chk32("divisor", divisor, b);
                chk1("div_signed", div_signed, op == OP_DIV);
            end
            if (k == 35) begin
                chk32("operand_hold", dividend, a);
                chk32("hi_before_commit", hi, exp_hi);
                chk32("lo_before_commit", lo, exp_lo);
            end
        end
        cyc();
        bubble();
        mid();
        chk32("commit_lo", lo, elo);
        chk32("commit_hi", hi, ehi);
        exp_lo = elo;
        exp_hi = ehi;
    endtask

    initial begin
        resetn = 1'b0;
        set_instr(OP_DIV, 32'd10, 32'd3);

        // Reset: ex_stall forced low even with a division in EX.
        cyc();
        cyc();
        mid();
        chk1("rst_stall", ex_stall, 1'b0);
        chk1("rst_div_en", div_en, 1'b0);
        chk1("rst_div_signed", div_signed, 1'b0);
        chk32("rst_dividend", dividend, 32'h0);
        chk32("rst_divisor", divisor, 32'h0);
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        cyc();
        resetn = 1'b1;
        bubble();

        div_seq(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        div_seq(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        // Flush at T+10 -> drain; a new DIVU at T+12 waits out the old result.
        cyc();
        set_instr(OP_DIVU, 32'd50, 32'd3);
        mid();
        chk1("drain_T_stall", ex_stall, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            mid();
        end
        cyc();
        ex_flush = 1'b1;
        mid();
        chk1("flush_T10_stall", ex_stall, 1'b0);
        cyc();
        bubble();
        mid();
        chk1("drain_bubble_stall", ex_stall, 1'b0);
        cyc();
        set_instr(OP_DIVU, 32'd9, 32'd4);
        mid();
        chk1("drain_newdiv_stall", ex_stall, 1'b1);
        for (int k = 13; k <= 35; k++) begin
            cyc();
            mid();
            chk1("drain_hold_stall", ex_stall, 1'b1);
            chk1("drain_no_issue", div_en, 1'b0);
        end
        div_seq(OP_DIVU, 32'd9, 32'd4, 32'd2, 32'd1);

        // MTHI/MTLO with a flushed MTHI at the end.
        cyc();
        set_instr(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        mid();
        chk1("mthi_stall", ex_stall, 1'b0);
        cyc();
        set_instr(OP_MTLO, 32'h1234_5678, 32'h0);
        mid();
        chk32("mthi_hi", hi, 32'hDEAD_BEEF);
        cyc();
        set_instr(OP_MTHI, 32'h1, 32'h0);
        ex_flush = 1'b1;
        mid();
        chk32("mtlo_lo", lo, 32'h1234_5678);
        cyc();
        bubble();
        mid();
        chk32("mthi_flushed_hi", hi, 32'hDEAD_BEEF);
        chk32("mt_lo_kept", lo, 32'h1234_5678);
        exp_hi = 32'hDEAD_BEEF;
        exp_lo = 32'h1234_5678;

        // Flush at issue suppresses it.
        cyc();
        set_instr(OP_DIVU, 32'd5, 32'd1);
        ex_flush = 1'b1;
        mid();
        chk1("issue_flush_stall", ex_stall, 1'b0);
        cyc();
        bubble();
        mid();
        chk1("issue_flush_no_en", div_en, 1'b0);
        cyc();
        mid();
        chk1("issue_flush_no_busy", div_busy, 1'b0);

        // Spurious completion in IDLE is ignored.
        cyc();
        spur     = 1'b1;
        spur_val = 32'hA5A5_A5A5;
        mid();
        chk1("spur_stall", ex_stall, 1'b0);
        cyc();
        spur = 1'b0;
        mid();
        chk32("spur_hi", hi, exp_hi);
        chk32("spur_lo", lo, exp_lo);

        // Flush coincident with completion: no write, back to IDLE directly.
        cyc();
        set_instr(OP_DIVU, 32'd20, 32'd6);
        for (int k = 1; k <= 34; k++) cyc();
        cyc();
        ex_flush = 1'b1;
        mid();
        chk1("flush_complete_stall", ex_stall, 1'b0);
        div_seq(OP_DIVU, 32'd20, 32'd6, 32'd3, 32'd2);

        // Reset in the middle of a division.
        cyc();
        set_instr(OP_DIVU, 32'd1000, 32'd3);
        for (int k = 1; k <= 19; k++) cyc();
        cyc();
        resetn = 1'b0;
        mid();
        chk1("midrst_stall", ex_stall, 1'b0);
        cyc();
        resetn = 1'b1;
        bubble();
        mid();
        chk32("midrst_hi", hi, 32'h0);
        chk32("midrst_lo", lo, 32'h0);
        chk1("midrst_div_en", div_en, 1'b0);
        chk1("midrst_stall_after", ex_stall, 1'b0);
        exp_hi = '0;
        exp_lo = '0;
        div_seq(OP_DIVU, 32'd6, 32'd3, 32'd2, 32'd0);

        // Divide by zero commits whatever the divider returns.
        div_seq(OP_DIVU, 32'h55, 32'd0, 32'hFFFF_FFFF, 32'h55);

        // Random instruction stream against the architectural HI/LO model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          fk;
            int          c;
            logic        is_d;
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            fk   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 45)) : -1;
            is_d = (op == OP_DIV) || (op == OP_DIVU);
            c    = 0;
            cyc();
            set_instr(op, a, b);
            ex_flush = (fk == 0);
            mid();
            while (ex_stall && c < 200) begin
                cyc();
                c++;
                ex_flush = (c == fk);
                mid();
            end
            chk1("rand_retire_budget", ex_stall, 1'b0);
            if (c != fk) begin
                if (is_d)
                    {exp_lo, exp_hi} = ref_div(op == OP_DIV, a, b);
                else if (op == OP_MTHI)
                    exp_hi = a;
                else if (op == OP_MTLO)
                    exp_lo = a;
            end
            cyc();
            bubble();
            mid();
            chk32("rand_hi", hi, exp_hi);
            chk32("rand_lo", lo, exp_lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage initiator for the iterative divider and owner of the architectural HI/LO registers. Decodes DIV/DIVU/MTHI/MTLO from EX and pulses the divider start for exactly one cycle. Stalls EX until the divider reports completion, then commits quotient to LO and remainder to HI. Handles pipeline flushes while a division is in flight by draining the divider and discarding its result.

## Interface
Parameters:
- None. Data width is fixed at 32 to match the divider.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset; shared with the divider.
- ex_valid  in  1  EX holds a valid instruction.
- ex_op  in  3  000 none, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO; other codes are treated as none.
- ex_rs_value  in  32  dividend, or MTHI/MTLO source.
- ex_rt_value  in  32  divisor.
- ex_flush  in  1  cancels the EX instruction this cycle.
- ex_stall  out  1  holds EX/ID/IF (combinational).
- div_en  out  1  divider start pulse (registered).
- div_signed  out  1  1 for DIV (registered).
- dividend  out  32  registered operand.
- divisor  out  32  registered operand.
- div_busy  in  1  divider busy.
- div_complete  in  1  quotient/remainder valid this cycle only.
- quotient  in  32  divider result.
- remainder  in  32  divider result.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States:
  - IDLE: no division outstanding.
  - WAIT: division issued; result will be committed.
  - DRAIN: division issued but cancelled; result will be discarded.
- Define is_div = ex_valid & (ex_op==DIV | ex_op==DIVU).
- IDLE:
  - If is_div & ~ex_flush & ~div_busy: latch dividend<=rs, divisor<=rt, div_signed<=(op==DIV); div_en<=1; go to WAIT.
  - If is_div & ~ex_flush & div_busy: stay in IDLE with ex_stall=1.
- WAIT:
  - div_en<=0 every cycle.
  - On div_complete & ~ex_flush: lo<=quotient, hi<=remainder; go to IDLE.
  - On ex_flush (with or without div_complete): no HI/LO write. If div_complete is also high, go to IDLE; otherwise go to DRAIN.
- DRAIN:
  - div_en=0.
  - On div_complete: discard result, go to IDLE.
  - Non-div instructions proceed normally.
- ex_stall:
  - IDLE: high when is_div & ~ex_flush. The issue cycle and any busy wait both stall.
  - WAIT: high unless div_complete or ex_flush.
  - DRAIN: high when is_div & ~ex_flush; the new division waits for IDLE.
- MTHI/MTLO: when ex_valid & ~ex_flush & ~ex_stall, hi<=rs (MTHI) or lo<=rs (MTLO). Flush suppresses the write.
- Divide by zero: commit whatever the divider returns. The controller never hangs and never inspects operand values.
- Spurious div_complete in IDLE is ignored.
- Operands are held stable in the dividend/divisor registers from div_en until the next issue.

## Timing
- Reset values: state IDLE, div_en 0, div_signed 0, dividend 0, divisor 0, hi 0, lo 0. ex_stall is forced 0 while resetn=0.
- Reset mid-division returns to IDLE; HI/LO are reset to 0 and the divider resets in the same cycle.
- Issue sequence, with the EX division first seen at cycle T:
  - div_en is high in T+1 only.
  - The team divider asserts div_complete at T+35 (PREPARE at T+2, 32 WORKING cycles T+3..T+34).
  - HI/LO change at the end of T+35 and are visible from T+36.
  - ex_stall is high T..T+34 and low at T+35; the instruction leaves EX at the end of T+35.
- Correctness must not depend on the exact latency; any div_complete arriving at T+2 or later is accepted.
- div_en is never high for two consecutive cycles.
- div_en is never asserted while div_busy is high or while in WAIT/DRAIN.
- A flush in the same cycle as the IDLE issue condition suppresses issue: no div_en, stays IDLE.
- MFHI/MFLO read hi/lo directly. A write at edge E is visible to any instruction reading after E; no bypass is required.

## Test plan
The bench uses a behavioural divider model with 35-cycle start-to-complete latency.
- DIVU rs=100, rt=7 at T -> div_en only at T+1, ex_stall 1 for T..T+34, lo=14, hi=2 at T+36.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> div_signed=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU issued, ex_flush at T+10 -> DRAIN, ex_stall 0 at T+10. A new DIVU 9/4 arriving at T+12 stalls until the drained div_complete, then issues. Final lo=2, hi=1; the first result is never written.
- MTHI 0xDEADBEEF, then MTLO 0x12345678, then MTHI 0x1 with ex_flush -> hi=0xDEADBEEF, lo=0x12345678.
- resetn low at T+20 of a division -> next cycle: state IDLE, hi=lo=0, div_en=0, ex_stall=0. A new DIVU 6/3 afterwards gives lo=2, hi=0.
- DIVU rt=0 with the model returning quotient 0xFFFFFFFF, remainder rs -> committed as returned, ex_stall released at T+35, no hang.
